// File: rtl/clock_reset_seq.sv
// clock_reset_seq: synchronises PLL lock, stretches/filters it into a clean domain reset and
// generates phase-aligned clock enables. Define CLOCK_RESET_LOSS_COUNT_EN to add loss_count.
module clock_reset_seq #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int LOSS_FILTER = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
`ifdef CLOCK_RESET_LOSS_COUNT_EN
    output logic [7:0]              loss_count,
`endif
    output logic                    domain_reset_n,
    output logic                    locked,
    output logic [NUM_CH-1:0]       ce
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int LOSS_W = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STRETCH   = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]       r_sync;
    state_t                       r_state;
    state_t                       w_next;
    logic [HOLD_W-1:0]            r_hold;
    logic [HOLD_W-1:0]            w_holdNext;
    logic [LOSS_W-1:0]            r_loss;
    logic [LOSS_W-1:0]            w_lossNext;
    logic                         r_run;
    logic [NUM_CH-1:0][DIV_W-1:0] r_div;
    logic [NUM_CH-1:0][DIV_W-1:0] r_cnt;
    logic [NUM_CH-1:0][DIV_W-1:0] w_divLast;
    logic [NUM_CH-1:0]            w_ce;
    logic                         w_lockedS;
    logic                         w_enterRun;

    assign w_lockedS  = r_sync[SYNC_STAGES-1];
    assign w_enterRun = (r_state != RUN) && (w_next == RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_state <= WAIT_LOCK;
            r_hold  <= '0;
            r_loss  <= '0;
            r_run   <= 1'b0;
            r_div   <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pll_locked};
            r_state <= w_next;
            r_hold  <= w_holdNext;
            r_loss  <= w_lossNext;
            r_run   <= (w_next == RUN);
            if (w_enterRun) begin
                r_div <= div_cfg;
            end
        end
    end

    // Hold and loss counters only live in their own state and restart from zero elsewhere.
    always_comb begin
        w_next     = r_state;
        w_holdNext = '0;
        w_lossNext = '0;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lockedS) begin
                    w_next = STRETCH;
                end
            end
            STRETCH: begin
                if (!w_lockedS) begin
                    w_next = WAIT_LOCK;
                end else if (r_hold == HOLD_LAST) begin
                    w_next = RUN;
                end else begin
                    w_holdNext = r_hold + 1'b1;
                end
            end
            RUN: begin
                if (!w_lockedS) begin
                    if (r_loss == LOSS_LAST) begin
                        w_next = WAIT_LOCK;
                    end else begin
                        w_lossNext = r_loss + 1'b1;
                    end
                end
            end
            default: w_next = WAIT_LOCK;
        endcase
    end

    // A zero divisor behaves as divide-by-one, so its terminal count is also zero.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_divLast[i] = (r_div[i] == '0) ? '0 : r_div[i] - 1'b1;
            w_ce[i]      = r_run && (r_cnt[i] == w_divLast[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!r_run || (r_cnt[i] == w_divLast[i])) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign domain_reset_n = r_run;
    assign locked         = r_run;
    assign ce             = w_ce;

`ifdef CLOCK_RESET_LOSS_COUNT_EN
    logic [7:0] r_lossCount;
    logic       w_leaveRun;

    assign w_leaveRun = (r_state == RUN) && (w_next != RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lossCount <= '0;
        end else if (w_leaveRun && (r_lossCount != 8'hFF)) begin
            r_lossCount <= r_lossCount + 8'd1;
        end
    end

    assign loss_count = r_lossCount;
`endif

endmodule

// File: tb/tb_clock_reset_seq.sv
// Self-checking bench for clock_reset_seq: directed lock/unlock/divisor scenarios checked against
// a streak-counting behavioural model every cycle, plus literal timing and pulse-count checks.
module tb_clock_reset_seq;
    localparam int NUM_CH      = 2;
    localparam int DIV_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYCLES = 16;
    localparam int LOSS_FILTER = 4;

    logic                    clock;
    logic                    reset_n;
    logic                    pll_locked;
    logic [NUM_CH*DIV_W-1:0] div_cfg;
    logic                    domain_reset_n;
    logic                    locked;
    logic [NUM_CH-1:0]       ce;
`ifdef CLOCK_RESET_LOSS_COUNT_EN
    logic [7:0]              loss_count;
`endif

    int nVectors     = 0;
    int nMiscompares = 0;

    clock_reset_seq #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .SYNC_STAGES (SYNC_STAGES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .LOSS_FILTER (LOSS_FILTER)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .div_cfg        (div_cfg),
`ifdef CLOCK_RESET_LOSS_COUNT_EN
        .loss_count     (loss_count),
`endif
        .domain_reset_n (domain_reset_n),
        .locked         (locked),
        .ce             (ce)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: the synchronised lock is the input seen SYNC_STAGES edges earlier. Outside RUN,
    // HOLD_CYCLES+1 consecutive synced highs release; in RUN, LOSS_FILTER consecutive lows drop.
    bit [SYNC_STAGES-1:0] mHist = '0;
    bit                   mSynced = 1'b0;
    bit                   mRun = 1'b0;
    int                   mHigh = 0;
    int                   mLow = 0;
    int                   mRunCycle = 0;
    int                   mDiv[NUM_CH];
    int                   mLossCount = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mHist = '0;
            mRun = 1'b0;
            mHigh = 0;
            mLow = 0;
            mRunCycle = 0;
            mLossCount = 0;
        end else begin
            mSynced = mHist[SYNC_STAGES-1];
            mHist = {mHist[SYNC_STAGES-2:0], pll_locked};
            if (!mRun) begin
                mHigh = mSynced ? mHigh + 1 : 0;
                if (mHigh == HOLD_CYCLES + 1) begin
                    mRun = 1'b1;
                    mRunCycle = 1;
                    mHigh = 0;
                    mLow = 0;
                    for (int i = 0; i < NUM_CH; i++) mDiv[i] = int'(div_cfg[i*DIV_W +: DIV_W]);
                end
            end else begin
                mLow = mSynced ? 0 : mLow + 1;
                if (mLow == LOSS_FILTER) begin
                    mRun = 1'b0;
                    mLow = 0;
                    mHigh = 0;
                    if (mLossCount < 255) mLossCount++;
                end else begin
                    mRunCycle++;
                end
            end
        end
    end

    function automatic logic [NUM_CH-1:0] expCe();
        logic [NUM_CH-1:0] v;
        int d;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            d = (mDiv[i] == 0) ? 1 : mDiv[i];
            v[i] = mRun && ((mRunCycle % d) == 0);
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every negative edge the DUT outputs must agree with the model.
    always @(negedge clock) begin
        checkOutput("cmpDomainReset", 32'(domain_reset_n), 32'(mRun));
        checkOutput("cmpLocked", 32'(locked), 32'(mRun));
        checkOutput("cmpCe", 32'(ce), 32'(expCe()));
`ifdef CLOCK_RESET_LOSS_COUNT_EN
        checkOutput("cmpLossCount", 32'(loss_count), 32'(mLossCount));
`endif
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic applyStimulus(input logic lock, input int cycles);
        pll_locked = lock;
        repeat (cycles) tick();
    endtask

    // Lock must already be high before the next edge; release is expected 18 edges after it.
    task automatic checkRelease(input string tag);
        for (int j = 0; j < 18; j++) begin
            tick();
            checkOutput({tag, "Pre"}, 32'({domain_reset_n, locked}), 32'd0);
        end
        tick();
        checkOutput(tag, 32'({domain_reset_n, locked}), 32'd3);
    endtask

    // Four synced lows drop RUN one edge after the last low is sampled by the synchroniser.
    task automatic lossAndRelock(input string tag);
        applyStimulus(1'b0, 4);
        pll_locked = 1'b1;
        tick();
        checkOutput({tag, "Pending"}, 32'(locked), 32'd1);
        tick();
        checkOutput({tag, "Exit"}, 32'({domain_reset_n, locked, ce}), 32'd0);
        repeat (16) tick();
        checkOutput({tag, "RelockPre"}, 32'(locked), 32'd0);
        tick();
        checkOutput({tag, "Relock"}, 32'({domain_reset_n, locked}), 32'd3);
    endtask

    initial begin
        int n0;
        int n1;
        int nBoth;
        int firstHit;

        reset_n    = 1'b0;
        pll_locked = 1'b0;
        div_cfg    = {8'd12, 8'd4};
        repeat (3) tick();
        checkOutput("resetOutputs", 32'({domain_reset_n, locked, ce}), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        checkOutput("noLockIdle", 32'(locked), 32'd0);

        $display("[TB] release timing and CE cadence /4 and /12");
        pll_locked = 1'b1;
        checkRelease("release");
        n0 = 0; n1 = 0; nBoth = 0;
        for (int c = 1; c <= 48; c++) begin
            if (ce[0]) n0++;
            if (ce[1]) n1++;
            if (ce == 2'b11) nBoth++;
            tick();
        end
        checkOutput("ce0Pulses48", 32'(n0), 32'd12);
        checkOutput("ce1Pulses48", 32'(n1), 32'd4);
        checkOutput("ceBoth48", 32'(nBoth), 32'd4);

        $display("[TB] divisor change during RUN is ignored");
        div_cfg = {8'd12, 8'd6};
        n0 = 0;
        for (int c = 49; c <= 60; c++) begin
            if (ce[0]) n0++;
            tick();
        end
        checkOutput("ce0KeepsDiv4", 32'(n0), 32'd3);

        $display("[TB] three-cycle unlock glitch is filtered");
        applyStimulus(1'b0, 3);
        pll_locked = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            checkOutput("glitchHold", 32'(locked), 32'd1);
        end

        $display("[TB] four-cycle unlock drops and relocks with new divisor");
        lossAndRelock("loss1");
        n0 = 0; n1 = 0;
        for (int c = 1; c <= 12; c++) begin
            if (ce[0]) n0++;
            if (ce[1]) n1++;
            tick();
        end
        checkOutput("ce0NewDiv6", 32'(n0), 32'd2);
        checkOutput("ce1AfterRelock", 32'(n1), 32'd1);
`ifdef CLOCK_RESET_LOSS_COUNT_EN
        checkOutput("lossCountOne", 32'(loss_count), 32'd1);
`endif

        $display("[TB] degenerate divisors 0 and 1");
        div_cfg = {8'd0, 8'd1};
        lossAndRelock("loss2");
        for (int c = 1; c <= 8; c++) begin
            checkOutput("ceAlwaysOn", 32'(ce), 32'd3);
            tick();
        end

        $display("[TB] maximum divisor 255");
        div_cfg = {8'd4, 8'd255};
        lossAndRelock("loss3");
        n0 = 0; firstHit = 0;
        for (int c = 1; c <= 510; c++) begin
            if (ce[0]) begin
                n0++;
                if (firstHit == 0) firstHit = c;
            end
            tick();
        end
        checkOutput("ce0Div255Pulses", 32'(n0), 32'd2);
        checkOutput("ce0Div255First", 32'(firstHit), 32'd255);
`ifdef CLOCK_RESET_LOSS_COUNT_EN
        checkOutput("lossCountThree", 32'(loss_count), 32'd3);
`endif

        $display("[TB] asynchronous reset mid-RUN");
        #1 reset_n = 1'b0;
        #1 checkOutput("asyncResetOutputs", 32'({domain_reset_n, locked, ce}), 32'd0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        checkRelease("asyncRelease");
`ifdef CLOCK_RESET_LOSS_COUNT_EN
        checkOutput("lossCountCleared", 32'(loss_count), 32'd0);
`endif
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
